dcache_ctrl: RTL

//  Direct-mapped, write-through, no-write-allocate L1 data cache between the MEM stage and main memory.

---
 rtl/dcache_pkg.sv | 25 ++
 rtl/dcache_line_store.sv | 64 ++++++
 rtl/dcache_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types, default geometry and address-field helpers for the L1 data cache
package dcache_pkg;

    localparam int LINES_DEF  = 16;
    localparam int WORDS_DEF  = 4;
    localparam int ADDR_W_DEF = 32;
    localparam int WORD_W     = 32;

    localparam int OFF_W_DEF = $clog2(WORDS_DEF);
    localparam int IDX_W_DEF = $clog2(LINES_DEF);
    localparam int TAG_W_DEF = ADDR_W_DEF - IDX_W_DEF - OFF_W_DEF - 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Generic field extract; callers size-cast the result to the field width.
    function automatic logic [63:0] addr_field(input logic [63:0] addr, input int lo, input int w);
        return (addr >> lo) & ((64'd1 << w) - 64'd1);
    endfunction

endpackage

// File: rtl/dcache_line_store.sv
// rtl/dcache_line_store.sv - valid/tag/data arrays with one combinational read port and refill/store/flush writes
module dcache_line_store
    import dcache_pkg::*;
#(
    parameter int LINES = LINES_DEF,
    parameter int WORDS = WORDS_DEF,
    parameter int IDX_W = IDX_W_DEF,
    parameter int OFF_W = OFF_W_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [OFF_W-1:0]  rd_word,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [WORD_W-1:0] rd_data,
    input  logic              fill_we,
    input  logic [IDX_W-1:0]  fill_idx,
    input  logic [OFF_W-1:0]  fill_word,
    input  logic [WORD_W-1:0] fill_data,
    input  logic              tag_we,
    input  logic [TAG_W-1:0]  tag_data,
    input  logic              st_we,
    input  logic [IDX_W-1:0]  st_idx,
    input  logic [OFF_W-1:0]  st_word,
    input  logic [WORD_W-1:0] st_data,
    input  logic              flash_clr
);

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [WORD_W-1:0] data_q [LINES*WORDS];

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[{rd_idx, rd_word}];

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            valid_q <= '0;
        end else if (flash_clr) begin
            valid_q <= '0;
        end else if (tag_we) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_q[fill_idx] <= tag_data;
        end
    end

    // Refill and store-hit occur in different FSM states, so they never collide.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_q[{fill_idx, fill_word}] <= fill_data;
        end else if (st_we) begin
            data_q[{st_idx, st_word}] <= st_data;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-through no-allocate L1 data cache controller
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES  = LINES_DEF,
    parameter int WORDS  = WORDS_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic              flush,
    output logic [WORD_W-1:0] req_rdata,
    output logic              CacheMiss,
    output logic              Ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata
);

    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;

    state_t state_q, state_d;
    logic [ADDR_W-1:0] cap_addr_q;
    logic [WORD_W-1:0] cap_wdata_q;
    logic [OFF_W-1:0]  beat_q;

    logic [TAG_W-1:0]  req_tag, cap_tag, rd_tag;
    logic [IDX_W-1:0]  req_idx, cap_idx;
    logic [OFF_W-1:0]  req_word;
    logic [WORD_W-1:0] rd_data;
    logic rd_valid, hit, take_req, start_txn, last_beat, fill_ack;
    logic unused_bits;

    assign req_word = OFF_W'(addr_field(64'(req_addr), 2, OFF_W));
    assign req_idx  = IDX_W'(addr_field(64'(req_addr), OFF_W + 2, IDX_W));
    assign req_tag  = TAG_W'(addr_field(64'(req_addr), OFF_W + 2 + IDX_W, TAG_W));
    assign cap_idx  = IDX_W'(addr_field(64'(cap_addr_q), OFF_W + 2, IDX_W));
    assign cap_tag  = TAG_W'(addr_field(64'(cap_addr_q), OFF_W + 2 + IDX_W, TAG_W));
    assign unused_bits = ^req_addr[1:0];

    assign hit       = rd_valid && (rd_tag == req_tag);
    assign take_req  = (state_q == IDLE) && req_valid;
    assign start_txn = take_req && (req_we || !hit);
    assign last_beat = (beat_q == OFF_W'(WORDS - 1));
    assign fill_ack  = (state_q == REFILL) && mem_ack;

    dcache_line_store #(
        .LINES(LINES), .WORDS(WORDS), .IDX_W(IDX_W), .OFF_W(OFF_W), .TAG_W(TAG_W)
    ) u_store (
        .clk       (clk),
        .nReset    (nReset),
        .rd_idx    (req_idx),
        .rd_word   (req_word),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .fill_we   (fill_ack),
        .fill_idx  (cap_idx),
        .fill_word (beat_q),
        .fill_data (mem_rdata),
        .tag_we    (fill_ack && last_beat),
        .tag_data  (cap_tag),
        .st_we     (take_req && req_we && hit),
        .st_idx    (req_idx),
        .st_word   (req_word),
        .st_data   (req_wdata),
        .flash_clr ((state_q == IDLE) && flush && !req_valid)
    );

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_txn) state_d = req_we ? WRITE : REFILL;
            REFILL:  if (mem_ack && last_beat) state_d = DONE;
            WRITE:   if (mem_ack) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_rdata = '0;
        CacheMiss = 1'b0;
        Ready     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            IDLE: begin
                CacheMiss = start_txn;
                req_rdata = (take_req && !req_we && hit) ? rd_data : '0;
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {cap_addr_q[ADDR_W-1:OFF_W+2], beat_q, 2'b00};
            end
            WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = cap_addr_q;
                mem_wdata = cap_wdata_q;
            end
            DONE:    Ready = 1'b1;
            default: Ready = 1'b0;
        endcase
    end

    // Captured request is held for the whole transaction so memory sees stable address/data.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            cap_addr_q  <= '0;
            cap_wdata_q <= '0;
            beat_q      <= '0;
        end else if (start_txn) begin
            cap_addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
            cap_wdata_q <= req_wdata;
            beat_q      <= '0;
        end else if (fill_ack) begin
            beat_q <= beat_q + 1'b1;
        end
    end

endmodule
